// File: rtl/bellek.sv
// Memory-access pipeline stage (bellek). ALU results pass through in one cycle.
// Loads and stores run one request/response transaction on the data-memory port.
// The pipeline stalls until the response, then the stage writes back the aligned, extended result.
module bellek #(
  parameter int unsigned VERI_BIT  = 32,
  parameter int unsigned MASKE_BIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // From the execute stage
  input  logic                 gecerli_i,
  input  logic                 yaz_yazmac_i,
  input  logic [4:0]           rd_adres_i,
  input  logic [VERI_BIT-1:0]  rd_deger_i,
  input  logic [VERI_BIT-1:0]  bellek_deger_i,
  input  logic                 bellek_oku_i,
  input  logic                 bellek_yaz_i,
  input  logic [1:0]           bellek_boyut_i,
  input  logic                 bellek_isaretsiz_i,
  // Data-memory port
  output logic                 vy_istek_gecerli_o,
  input  logic                 vy_istek_hazir_i,
  output logic [VERI_BIT-1:0]  vy_adres_o,
  output logic [VERI_BIT-1:0]  vy_veri_o,
  output logic [MASKE_BIT-1:0] vy_maske_o,
  output logic                 vy_yaz_o,
  input  logic                 vy_cevap_gecerli_i,
  input  logic [VERI_BIT-1:0]  vy_cevap_veri_i,
  // Pipeline control and writeback
  output logic                 durdur_o,
  output logic                 hizasiz_o,
  output logic                 gecerli_o,
  output logic                 yaz_yazmac_o,
  output logic [4:0]           rd_adres_o,
  output logic [VERI_BIT-1:0]  rd_deger_o
);

  typedef enum logic [1:0] {
    StBosta = 2'd0,
    StIstek = 2'd1,
    StCevap = 2'd2
  } durum_e;

  durum_e durum_q, durum_d;

  // Latched transaction fields
  logic [VERI_BIT-1:0]  adres_q, adres_d;
  logic [VERI_BIT-1:0]  veri_q, veri_d;
  logic [MASKE_BIT-1:0] maske_q, maske_d;
  logic                 yaz_q, yaz_d;
  logic [1:0]           boyut_q, boyut_d;
  logic                 isaretsiz_q, isaretsiz_d;
  logic [4:0]           rd_q, rd_d;

  // Registered writeback outputs
  logic                 gecerli_q, gecerli_d;
  logic                 yaz_yazmac_q, yaz_yazmac_d;
  logic                 hizasiz_q, hizasiz_d;
  logic [4:0]           rd_adres_q, rd_adres_d;
  logic [VERI_BIT-1:0]  rd_deger_q, rd_deger_d;

  logic                 bellek_op;
  logic                 hizali;
  logic [MASKE_BIT-1:0] maske_yeni;
  logic [VERI_BIT-1:0]  veri_yeni;
  logic [VERI_BIT-1:0]  kaydirilmis;
  logic [7:0]           bayt;
  logic [15:0]          yarim;
  logic [VERI_BIT-1:0]  yukleme;

  // Decode the incoming access: alignment and store lane placement
  always_comb begin
    bellek_op  = bellek_oku_i | bellek_yaz_i;
    hizali     = 1'b1;
    maske_yeni = {MASKE_BIT{1'b1}};
    veri_yeni  = bellek_deger_i;
    unique case (bellek_boyut_i)
      2'b00: begin
        maske_yeni = {{(MASKE_BIT-1){1'b0}}, 1'b1} << rd_deger_i[1:0];
        veri_yeni  = {MASKE_BIT{bellek_deger_i[7:0]}};
      end
      2'b01: begin
        hizali     = ~rd_deger_i[0];
        maske_yeni = rd_deger_i[1] ? 4'b1100 : 4'b0011;
        veri_yeni  = {2{bellek_deger_i[15:0]}};
      end
      default: begin
        hizali = (rd_deger_i[1:0] == 2'b00);
      end
    endcase
    // Loads always read the full word; the lane is picked on the response
    if (bellek_oku_i) begin
      maske_yeni = {MASKE_BIT{1'b1}};
    end
  end

  // Extract and extend the load result from the response word
  always_comb begin
    kaydirilmis = vy_cevap_veri_i >> {adres_q[1:0], 3'b000};
    bayt        = kaydirilmis[7:0];
    yarim       = adres_q[1] ? vy_cevap_veri_i[31:16] : vy_cevap_veri_i[15:0];
    unique case (boyut_q)
      2'b00:   yukleme = {{(VERI_BIT-8){~isaretsiz_q & bayt[7]}}, bayt};
      2'b01:   yukleme = {{(VERI_BIT-16){~isaretsiz_q & yarim[15]}}, yarim};
      default: yukleme = vy_cevap_veri_i;
    endcase
  end

  // Next-state, stall and writeback logic
  always_comb begin
    durum_d      = durum_q;
    adres_d      = adres_q;
    veri_d       = veri_q;
    maske_d      = maske_q;
    yaz_d        = yaz_q;
    boyut_d      = boyut_q;
    isaretsiz_d  = isaretsiz_q;
    rd_d         = rd_q;
    gecerli_d    = 1'b0;
    yaz_yazmac_d = 1'b0;
    hizasiz_d    = 1'b0;
    rd_adres_d   = rd_adres_q;
    rd_deger_d   = rd_deger_q;
    durdur_o     = 1'b0;

    unique case (durum_q)
      StBosta: begin
        if (gecerli_i && bellek_op) begin
          if (!hizali) begin
            // Misaligned: no request, retire as a non-writing entry
            hizasiz_d  = 1'b1;
            gecerli_d  = 1'b1;
            rd_adres_d = rd_adres_i;
            rd_deger_d = rd_deger_i;
          end else begin
            durdur_o    = 1'b1;
            adres_d     = rd_deger_i;
            veri_d      = veri_yeni;
            maske_d     = maske_yeni;
            // A load wins when both load and store are flagged
            yaz_d       = bellek_yaz_i & ~bellek_oku_i;
            boyut_d     = bellek_boyut_i;
            isaretsiz_d = bellek_isaretsiz_i;
            rd_d        = rd_adres_i;
            durum_d     = StIstek;
          end
        end else begin
          gecerli_d    = gecerli_i;
          yaz_yazmac_d = gecerli_i & yaz_yazmac_i & (rd_adres_i != 5'd0);
          rd_adres_d   = rd_adres_i;
          rd_deger_d   = rd_deger_i;
        end
      end
      StIstek: begin
        durdur_o = 1'b1;
        if (vy_istek_hazir_i) begin
          durum_d = StCevap;
        end
      end
      StCevap: begin
        if (vy_cevap_gecerli_i) begin
          // Stall drops in the response cycle so upstream advances at this edge
          durum_d    = StBosta;
          gecerli_d  = 1'b1;
          rd_adres_d = rd_q;
          if (!yaz_q) begin
            yaz_yazmac_d = (rd_q != 5'd0);
            rd_deger_d   = yukleme;
          end else begin
            rd_deger_d = '0;
          end
        end else begin
          durdur_o = 1'b1;
        end
      end
      default: begin
        durum_d = StBosta;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q      <= StBosta;
      adres_q      <= '0;
      veri_q       <= '0;
      maske_q      <= '0;
      yaz_q        <= 1'b0;
      boyut_q      <= 2'b00;
      isaretsiz_q  <= 1'b0;
      rd_q         <= 5'd0;
      gecerli_q    <= 1'b0;
      yaz_yazmac_q <= 1'b0;
      hizasiz_q    <= 1'b0;
      rd_adres_q   <= 5'd0;
      rd_deger_q   <= '0;
    end else begin
      durum_q      <= durum_d;
      adres_q      <= adres_d;
      veri_q       <= veri_d;
      maske_q      <= maske_d;
      yaz_q        <= yaz_d;
      boyut_q      <= boyut_d;
      isaretsiz_q  <= isaretsiz_d;
      rd_q         <= rd_d;
      gecerli_q    <= gecerli_d;
      yaz_yazmac_q <= yaz_yazmac_d;
      hizasiz_q    <= hizasiz_d;
      rd_adres_q   <= rd_adres_d;
      rd_deger_q   <= rd_deger_d;
    end
  end

  assign vy_istek_gecerli_o = (durum_q == StIstek);
  assign vy_adres_o         = {adres_q[VERI_BIT-1:2], 2'b00};
  assign vy_veri_o          = veri_q;
  assign vy_maske_o         = maske_q;
  assign vy_yaz_o           = yaz_q;
  assign hizasiz_o          = hizasiz_q;
  assign gecerli_o          = gecerli_q;
  assign yaz_yazmac_o       = yaz_yazmac_q;
  assign rd_adres_o         = rd_adres_q;
  assign rd_deger_o         = rd_deger_q;

endmodule

// File: tb/tb_bellek.sv
// Self-checking bench for bellek: directed scenarios plus randomized operations
// against a transaction-level reference model.
module tb_bellek;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        gecerli_i, yaz_yazmac_i;
  logic [4:0]  rd_adres_i;
  logic [31:0] rd_deger_i, bellek_deger_i;
  logic        bellek_oku_i, bellek_yaz_i;
  logic [1:0]  bellek_boyut_i;
  logic        bellek_isaretsiz_i;
  logic        vy_istek_gecerli_o, vy_istek_hazir_i;
  logic [31:0] vy_adres_o, vy_veri_o;
  logic [3:0]  vy_maske_o;
  logic        vy_yaz_o, vy_cevap_gecerli_i;
  logic [31:0] vy_cevap_veri_i;
  logic        durdur_o, hizasiz_o, gecerli_o, yaz_yazmac_o;
  logic [4:0]  rd_adres_o;
  logic [31:0] rd_deger_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  bellek dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .gecerli_i          (gecerli_i),
    .yaz_yazmac_i       (yaz_yazmac_i),
    .rd_adres_i         (rd_adres_i),
    .rd_deger_i         (rd_deger_i),
    .bellek_deger_i     (bellek_deger_i),
    .bellek_oku_i       (bellek_oku_i),
    .bellek_yaz_i       (bellek_yaz_i),
    .bellek_boyut_i     (bellek_boyut_i),
    .bellek_isaretsiz_i (bellek_isaretsiz_i),
    .vy_istek_gecerli_o (vy_istek_gecerli_o),
    .vy_istek_hazir_i   (vy_istek_hazir_i),
    .vy_adres_o         (vy_adres_o),
    .vy_veri_o          (vy_veri_o),
    .vy_maske_o         (vy_maske_o),
    .vy_yaz_o           (vy_yaz_o),
    .vy_cevap_gecerli_i (vy_cevap_gecerli_i),
    .vy_cevap_veri_i    (vy_cevap_veri_i),
    .durdur_o           (durdur_o),
    .hizasiz_o          (hizasiz_o),
    .gecerli_o          (gecerli_o),
    .yaz_yazmac_o       (yaz_yazmac_o),
    .rd_adres_o         (rd_adres_o),
    .rd_deger_o         (rd_deger_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: size 3 behaves as word
  function automatic int unsigned sz_of(input logic [1:0] boyut);
    return (boyut == 2'b11) ? 2 : int'(boyut);
  endfunction

  function automatic logic ref_aligned(input logic [1:0] boyut, input int unsigned off);
    case (sz_of(boyut))
      0:       return 1'b1;
      1:       return (off % 2) == 0;
      default: return off == 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_mask(input logic load, input logic [1:0] boyut,
                                          input int unsigned off);
    if (load) return 4'd15;
    case (sz_of(boyut))
      0:       return 4'(1 << off);
      1:       return (off >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] boyut, input logic [31:0] d);
    case (sz_of(boyut))
      0:       return (d & 32'hFF) * 32'h0101_0101;
      1:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] boyut, input int unsigned off,
                                           input logic uns, input logic [31:0] w);
    logic [31:0] v;
    case (sz_of(boyut))
      0: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      1: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic set_idle();
    gecerli_i          = 1'b0;
    yaz_yazmac_i       = 1'b0;
    bellek_oku_i       = 1'b0;
    bellek_yaz_i       = 1'b0;
    rd_adres_i         = 5'($urandom);
    rd_deger_i         = $urandom;
    bellek_deger_i     = $urandom;
    bellek_boyut_i     = 2'($urandom);
    bellek_isaretsiz_i = 1'($urandom);
    vy_istek_hazir_i   = 1'($urandom);
    vy_cevap_gecerli_i = 1'($urandom);
    vy_cevap_veri_i    = $urandom;
  endtask

  // Drive one instruction and follow it until its writeback, checking every cycle
  task automatic run_op(input logic v, input logic oku, input logic yaz, input logic [1:0] boyut,
                        input logic uns, input logic [4:0] rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] resp, input int hz_wait, input int rsp_wait);
    logic        mem, load, al;
    int unsigned off;
    mem  = v && (oku || yaz);
    load = oku;
    off  = int'(addr[1:0]);
    al   = ref_aligned(boyut, off);

    @(posedge clk_i); #1;
    gecerli_i          = v;
    yaz_yazmac_i       = wr;
    rd_adres_i         = rd;
    rd_deger_i         = addr;
    bellek_deger_i     = sdata;
    bellek_oku_i       = oku;
    bellek_yaz_i       = yaz;
    bellek_boyut_i     = boyut;
    bellek_isaretsiz_i = uns;
    @(negedge clk_i);
    check_eq("c0_no_extra_wb", 32'(gecerli_o), 32'd0);
    check_eq("c0_hizasiz", 32'(hizasiz_o), 32'd0);
    check_eq("c0_istek", 32'(vy_istek_gecerli_o), 32'd0);
    check_eq("c0_durdur", 32'(durdur_o), 32'(mem && al));

    if (!mem) begin
      @(posedge clk_i); #1; set_idle();
      @(negedge clk_i);
      check_eq("alu_gecerli", 32'(gecerli_o), 32'(v));
      check_eq("alu_durdur", 32'(durdur_o), 32'd0);
      if (v) begin
        check_eq("alu_yaz", 32'(yaz_yazmac_o), 32'(wr && rd != 5'd0));
        check_eq("alu_rd", 32'(rd_adres_o), 32'(rd));
        check_eq("alu_deger", rd_deger_o, addr);
      end
    end else if (!al) begin
      @(posedge clk_i); #1; set_idle();
      @(negedge clk_i);
      check_eq("mis_hizasiz", 32'(hizasiz_o), 32'd1);
      check_eq("mis_gecerli", 32'(gecerli_o), 32'd1);
      check_eq("mis_yaz", 32'(yaz_yazmac_o), 32'd0);
      check_eq("mis_istek", 32'(vy_istek_gecerli_o), 32'd0);
    end else begin
      for (int i = 0; i <= hz_wait; i++) begin
        @(posedge clk_i); #1;
        vy_istek_hazir_i   = (i == hz_wait);
        vy_cevap_gecerli_i = 1'($urandom);
        vy_cevap_veri_i    = $urandom;
        @(negedge clk_i);
        check_eq("req_valid", 32'(vy_istek_gecerli_o), 32'd1);
        check_eq("req_adres", vy_adres_o, {addr[31:2], 2'b00});
        check_eq("req_maske", 32'(vy_maske_o), 32'(ref_mask(load, boyut, off)));
        check_eq("req_yaz", 32'(vy_yaz_o), 32'(!load));
        if (!load) check_eq("req_veri", vy_veri_o, ref_wdata(boyut, sdata));
        check_eq("req_durdur", 32'(durdur_o), 32'd1);
        check_eq("req_no_wb", 32'(gecerli_o), 32'd0);
      end
      for (int k = 0; k <= rsp_wait; k++) begin
        @(posedge clk_i); #1;
        vy_istek_hazir_i   = 1'($urandom);
        vy_cevap_gecerli_i = (k == rsp_wait);
        vy_cevap_veri_i    = (k == rsp_wait) ? resp : $urandom;
        @(negedge clk_i);
        check_eq("rsp_istek_low", 32'(vy_istek_gecerli_o), 32'd0);
        check_eq("rsp_durdur", 32'(durdur_o), 32'(k != rsp_wait));
        check_eq("rsp_no_wb", 32'(gecerli_o), 32'd0);
      end
      @(posedge clk_i); #1; set_idle();
      @(negedge clk_i);
      check_eq("wb_gecerli", 32'(gecerli_o), 32'd1);
      check_eq("wb_hizasiz", 32'(hizasiz_o), 32'd0);
      check_eq("wb_rd", 32'(rd_adres_o), 32'(rd));
      check_eq("wb_yaz", 32'(yaz_yazmac_o), 32'(load && rd != 5'd0));
      check_eq("wb_deger", rd_deger_o, load ? ref_load(boyut, off, uns, resp) : 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    set_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_gecerli", 32'(gecerli_o), 32'd0);
    check_eq("rst_yaz", 32'(yaz_yazmac_o), 32'd0);
    check_eq("rst_istek", 32'(vy_istek_gecerli_o), 32'd0);
    check_eq("rst_maske", 32'(vy_maske_o), 32'd0);
    check_eq("rst_hizasiz", 32'(hizasiz_o), 32'd0);
    check_eq("rst_deger", rd_deger_o, 32'd0);
    rst_i = 1'b1;

    // ALU pass-through
    run_op(1, 0, 0, 2'b10, 0, 5'd5, 1, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    // LB / LBU at minimum latency
    run_op(1, 1, 0, 2'b00, 0, 5'd3, 1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    run_op(1, 1, 0, 2'b00, 1, 5'd3, 1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    // SH upper half
    run_op(1, 0, 1, 2'b01, 0, 5'd4, 0, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 0, 0);
    // Backpressure on request and response
    run_op(1, 1, 0, 2'b10, 0, 5'd9, 1, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 4, 3);
    // Misaligned LW
    run_op(1, 1, 0, 2'b10, 0, 5'd6, 1, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
    // Both load and store flagged: treated as a load
    run_op(1, 1, 1, 2'b01, 0, 5'd8, 1, 32'h0000_5002, 32'h1234_5678, 32'h8001_7FFF, 1, 1);

    // Reset while waiting for a response
    @(posedge clk_i); #1;
    gecerli_i = 1; yaz_yazmac_i = 1; rd_adres_i = 5'd7; rd_deger_i = 32'h0000_4000;
    bellek_oku_i = 1; bellek_yaz_i = 0; bellek_boyut_i = 2'b10; bellek_isaretsiz_i = 0;
    @(posedge clk_i); #1; vy_istek_hazir_i = 1; vy_cevap_gecerli_i = 0;
    @(posedge clk_i); #1; vy_cevap_gecerli_i = 0; rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("cevap_wait_durdur", 32'(durdur_o), 32'd1);
    @(posedge clk_i); #1; rst_i = 1'b1; set_idle(); vy_cevap_gecerli_i = 0;
    @(negedge clk_i);
    check_eq("mrst_gecerli", 32'(gecerli_o), 32'd0);
    check_eq("mrst_istek", 32'(vy_istek_gecerli_o), 32'd0);
    check_eq("mrst_durdur", 32'(durdur_o), 32'd0);
    check_eq("mrst_maske", 32'(vy_maske_o), 32'd0);
    check_eq("mrst_rd", 32'(rd_adres_o), 32'd0);
    @(posedge clk_i); #1; vy_cevap_gecerli_i = 1; vy_cevap_veri_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_eq("late_rsp_durdur", 32'(durdur_o), 32'd0);
    @(posedge clk_i); #1; vy_cevap_gecerli_i = 0;
    @(negedge clk_i);
    check_eq("late_rsp_no_wb", 32'(gecerli_o), 32'd0);
    run_op(1, 0, 0, 2'b10, 0, 5'd12, 1, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 0);
    // LW to x0 must not write
    run_op(1, 1, 0, 2'b10, 0, 5'd0, 1, 32'h0000_6000, 32'h0, 32'h1111_2222, 0, 0);

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0]  sel;
      a   = $urandom;
      sel = 2'($urandom);
      run_op(($urandom_range(0, 7) != 0), sel[0], sel[1], 2'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bellek.md
Name: bellek

Overview:
- Memory-access pipeline stage directly downstream of the execute stage (yurut); upstream of the register-file writeback.
- Non-memory results pass through in one cycle.
- Loads and stores run a request/response handshake on the data-memory port, stall the pipeline until completion, then present the aligned, extended writeback result.

Parameters:
- VERI_BIT, 32, data and address width
- MASKE_BIT, 4, byte-enable width (VERI_BIT/8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- gecerli_i  in  1  instruction from yurut is valid
- yaz_yazmac_i  in  1  instruction writes rd
- rd_adres_i  in  5  destination register
- rd_deger_i  in  32  yurut result; the effective address for memory ops
- bellek_deger_i  in  32  store data (rs2)
- bellek_oku_i  in  1  load
- bellek_yaz_i  in  1  store
- bellek_boyut_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- bellek_isaretsiz_i  in  1  zero-extend load (LBU/LHU)
- vy_istek_gecerli_o  out  1  memory request valid
- vy_istek_hazir_i  in  1  memory accepts request
- vy_adres_o  out  32  word-aligned address ({addr[31:2],2'b00})
- vy_veri_o  out  32  store data, lane-replicated
- vy_maske_o  out  4  byte enables
- vy_yaz_o  out  1  1 = store, 0 = load
- vy_cevap_gecerli_i  in  1  response/ack valid
- vy_cevap_veri_i  in  32  load word
- durdur_o  out  1  stall: upstream holds all inputs stable
- hizasiz_o  out  1  one-cycle misaligned-access pulse
- gecerli_o  out  1  writeback entry valid
- yaz_yazmac_o  out  1  register write enable
- rd_adres_o  out  5  destination register
- rd_deger_o  out  32  writeback value

Behaviour:
- Reset (rst_i==0 at posedge):
  - State = BOSTA.
  - All registered outputs = 0; vy_istek_gecerli_o = 0, vy_maske_o = 0, hizasiz_o = 0.
  - Mid-transaction reset drops the request; any later vy_cevap_gecerli_i is ignored.
- FSM states: BOSTA, ISTEK, CEVAP.
- BOSTA, no memory op (or gecerli_i = 0):
  - Next cycle: gecerli_o = gecerli_i, yaz_yazmac_o = yaz_yazmac_i && rd_adres_i != 0, rd_adres_o, rd_deger_o = rd_deger_i.
  - durdur_o = 0; latency 1.
- BOSTA, gecerli_i with oku or yaz:
  - If both oku and yaz are set, the access is a load.
  - Alignment check: half requires addr[0] = 0; word requires addr[1:0] = 0.
  - Misaligned:
    - No request; durdur_o = 0.
    - Next cycle: hizasiz_o = 1 (one cycle), gecerli_o = 1, yaz_yazmac_o = 0.
  - Aligned:
    - durdur_o = 1 combinationally this cycle.
    - Request fields are latched; next state ISTEK.
- ISTEK:
  - vy_istek_gecerli_o = 1; address, data, mask and yaz held stable until vy_istek_hazir_i = 1.
  - On handshake: next state CEVAP, vy_istek_gecerli_o drops next cycle.
  - durdur_o = 1 throughout.
- CEVAP:
  - Wait for vy_cevap_gecerli_i; durdur_o = 1 while waiting.
  - In the response cycle, durdur_o = 0 (combinational), so upstream advances at that edge.
  - Next cycle: outputs written, state BOSTA.
  - Load: yaz_yazmac_o = (rd_adres != 0), rd_deger_o = aligned, extended data.
  - Store: gecerli_o = 1, yaz_yazmac_o = 0, rd_deger_o = 0.
- vy_cevap_gecerli_i outside CEVAP: ignored.
- Only one outstanding transaction.
- Store lanes:
  - Byte: mask = 4'b0001 << addr[1:0]; data = {4{byte}}.
  - Half: mask = addr[1] ? 1100 : 0011; data = {2{half}}.
  - Word: mask = 1111, data = rs2.
  - Load: mask = 1111.
- Load extraction:
  - Byte at lane addr[1:0]; half at addr[1] ? [31:16] : [15:0].
  - Sign-extend unless bellek_isaretsiz_i; word is passed through.
- Registered outputs not updated by an event in a given cycle: gecerli_o = 0, yaz_yazmac_o = 0, hizasiz_o = 0; rd_adres_o/rd_deger_o hold.
- Minimum memory-op latency (hazir = 1, response one cycle after handshake):
  - Accept in cycle 0, handshake in cycle 1, response in cycle 2, result visible in cycle 3.
  - durdur_o high in cycles 0–1.

Test Plan:
1. ALU pass-through: gecerli_i = 1, no mem op, rd = 5, rd_deger_i = 0x1234 -> next cycle gecerli_o = 1, yaz_yazmac_o = 1, rd_adres_o = 5, rd_deger_o = 0x1234, durdur_o never high.
2. LB signed:
   - Stimulus: addr 0x1003, response 0x80FF_0000; hazir = 1; response one cycle after handshake.
   - Required request: vy_adres_o = 0x1000, mask 1111, vy_yaz_o = 0.
   - Required result: rd_deger_o = 0xFFFF_FF80 in cycle 3; durdur_o = 1 for exactly cycles 0–1.
   - LBU on the same address -> 0x0000_0080.
3. SH at addr 0x2002, rs2 = 0xAAAA_BEEF -> vy_adres_o = 0x2000, vy_veri_o = 0xBEEF_BEEF, vy_maske_o = 1100, vy_yaz_o = 1; after ack gecerli_o = 1, yaz_yazmac_o = 0.
4. Backpressure:
   - Stimulus: vy_istek_hazir_i = 0 for 4 cycles, then response delayed 3 cycles.
   - Required: request fields stable throughout; durdur_o = 1 until the response cycle; exactly one writeback.
5. LW at addr 0x3001 -> no vy_istek_gecerli_o, hizasiz_o = 1 for one cycle, gecerli_o = 1, yaz_yazmac_o = 0.
6. Reset (rst_i = 0) asserted while in CEVAP -> all outputs 0, state BOSTA; a late vy_cevap_gecerli_i produces no writeback; next ALU op proceeds normally. LW to rd = 0 -> yaz_yazmac_o = 0.
